axi_ar_route_decoder: RTL and testbench
=======================================

Name: axi_ar_route_decoder

Overview:
Address-decode and steering stage for the AR channel of one target port. It sits directly upstream of that port's read-data backward allocator.
- Matches each incoming read address against a per-initiator region table and raises arvalid toward exactly one initiator port.
- Pulses incr_req for the allocator's outstanding counter on every routed acceptance.
- On an address miss, accepts the AR itself, hands len/id/user to the allocator and holds error_req until the DECERR burst is granted.

Parameters:
- N_INIT_PORT, 2, number of initiator (downstream) ports.
- N_REGION, 2, address regions per initiator port.
- AXI_ADDR_W, 32, address width.
- AXI_ID_IN, 16, target-side ID width.
- AXI_USER_W, 6, user width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- arvalid_i  in  1  AR valid from target port
- araddr_i  in  AXI_ADDR_W  read address
- arlen_i  in  8  burst length minus 1
- arid_i  in  AXI_ID_IN  read ID
- aruser_i  in  AXI_USER_W  user field
- arready_o  out  1  AR ready to target port
- arvalid_o  out  N_INIT_PORT  one-hot steered valid
- arready_i  in  N_INIT_PORT  ready from initiator ports
- START_ADDR_i  in  N_REGION x N_INIT_PORT x AXI_ADDR_W  region base, inclusive
- END_ADDR_i  in  N_REGION x N_INIT_PORT x AXI_ADDR_W  region end, inclusive
- enable_region_i  in  N_REGION x N_INIT_PORT  region enable
- connectivity_map_i  in  N_INIT_PORT  target-to-initiator reachability
- incr_req_o  out  1  outstanding counter increment
- full_counter_i  in  1  allocator counter saturated
- error_req_o  out  1  DECERR burst request
- error_gnt_i  in  1  DECERR burst completed
- error_len_o  out  8  error burst length
- error_id_o  out  AXI_ID_IN  error ID
- error_user_o  out  AXI_USER_W  error user
- sample_ardata_info_o  out  1  capture strobe for error info

Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.

Behaviour:
- Hit rule: hit[j] = connectivity_map_i[j] & OR over r of (enable_region_i[r][j] & START <= araddr_i <= END). Compare unsigned, both ends inclusive.
- Multiple hits: the lowest-index j wins (sel). Miss: no hit[j] set.
- States: OPERATIVE, ERROR.
- Reset: state is OPERATIVE and the err_len/id/user registers are 0. While rst=1, all outputs except error_*_o are forced to 0.
- OPERATIVE with full_counter_i=1: arvalid_o=0 and arready_o=0. Neither hits nor misses are accepted.
- OPERATIVE, arvalid_i=1, hit:
  - arvalid_o[sel]=1, all other bits 0.
  - arready_o=arready_i[sel], combinational, zero latency.
  - incr_req_o = arvalid_i & arready_i[sel].
- OPERATIVE, arvalid_i=1, miss:
  - arready_o=1, arvalid_o=0, sample_ardata_info_o=1.
  - Capture arlen_i/arid_i/aruser_i into registers.
  - Next state ERROR. error_req_o is 0 in this cycle.
- error_*_o source:
  - In OPERATIVE: error_*_o = arlen_i/arid_i/aruser_i, combinational, so the downstream sample in the acceptance cycle sees current values.
  - In ERROR: error_*_o = the captured registers, held stable for the whole burst.
- ERROR:
  - error_req_o=1, arready_o=0, arvalid_o=0, incr_req_o=0, sample_ardata_info_o=0.
  - On error_gnt_i=1: next state OPERATIVE; error_req_o stays 1 in that cycle.
  - The earliest next acceptance is the following cycle.
- error_gnt_i while in OPERATIVE is ignored.
- Valid stability: arvalid_o[sel] depends only on the held AR inputs and static config, so it stays stable until the handshake completes.
- Config inputs may change only while no AR is pending. Behaviour is undefined otherwise.
- Reset mid-ERROR: next cycle is OPERATIVE with error_req_o=0. No gnt is required.

Decomposition:
- Shared package axi_node_pkg:
  - RESP_DECERR constant;
  - AR decoder state enum;
  - typedefs for the region address table and enable matrix.
- One sub-module, axi_region_match: combinational per-initiator region comparator plus lowest-index priority encoder. Produces hit, sel and miss.

Test Plan:
Common config for all scenarios:
- N_INIT_PORT=2.
- Port0 region0 = 0x1000_0000–0x1FFF_FFFF; port1 region0 = 0x2000_0000–0x2FFF_FFFF.
- connectivity_map_i=2'b11.

Scenarios:
1. Routed hit: araddr 0x1000_0004, arready_i=2'b01 → same cycle arvalid_o=2'b01, arready_o=1, incr_req_o=1.
2. Miss: araddr 0x3000_0000, arlen 3, arid 5, aruser 2 → arready_o=1, sample=1, error_len_o=3. Next cycle error_req_o=1, arready_o=0, error_len_o/id/user=3/5/2 while arlen_i is changed to 0. After error_gnt_i, OPERATIVE next cycle and a new AR is accepted.
3. full_counter_i=1 with hit 0x2000_0000 → arvalid_o=0, arready_o=0 for 5 cycles. Drop full → arvalid_o=2'b10, accepted on arready_i[1].
4. Priority and connectivity:
   - Enable port0 region1 = 0x2000_0000–0x2000_FFFF and send 0x2000_0010 → arvalid_o=2'b01.
   - Set connectivity_map_i=2'b10 → arvalid_o=2'b10.
   - Set connectivity_map_i=2'b00 → miss path.
5. Boundaries:
   - 0x1FFF_FFFF → port0; 0x2000_0000 → port1.
   - Disable port1 region0 and send 0x2000_0000 → miss.
6. Reset in ERROR: assert rst 1 cycle → error_req_o=0 next cycle, no gnt needed. A hit AR is accepted immediately after.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared types and constants for the AXI node AR routing path.
// Imported by the decoder, its region matcher and the bench.
package axi_node_pkg;

  localparam int DEF_N_INIT_PORT = 2;
  localparam int DEF_N_REGION    = 2;
  localparam int DEF_ADDR_W      = 32;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    AR_OPERATIVE = 1'b0,
    AR_ERROR     = 1'b1
  } ar_dec_state_e;

  typedef logic [DEF_N_REGION-1:0][DEF_N_INIT_PORT-1:0][DEF_ADDR_W-1:0]
    region_addr_t;

  typedef logic [DEF_N_REGION-1:0][DEF_N_INIT_PORT-1:0] region_en_t;

endpackage

// File: rtl/axi_region_match.sv
// Per-initiator region comparator with lowest-index priority.
// Produces the raw hit vector, a one-hot winner and a miss flag.
module axi_region_match
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 2,
  parameter int N_REGION    = 2,
  parameter int AXI_ADDR_W  = 32
) (
  input  logic [AXI_ADDR_W-1:0]                            addr,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]             enable,
  input  logic [N_INIT_PORT-1:0]                           conn,
  output logic [N_INIT_PORT-1:0]                           hit,
  output logic [N_INIT_PORT-1:0]                           sel,
  output logic                                             miss
);

  logic found;

  always_comb begin
    hit = '0;
    for (int j = 0; j < N_INIT_PORT; j++) begin
      for (int r = 0; r < N_REGION; r++) begin
        if (enable[r][j] &&
            addr >= start_addr[r][j] &&
            addr <= end_addr[r][j]) begin
          hit[j] = conn[j];
        end
      end
    end
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int j = 0; j < N_INIT_PORT; j++) begin
      if (hit[j] && !found) begin
        sel[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign miss = ~|hit;

endmodule

// File: rtl/axi_ar_route_decoder.sv
// AR address decode and steering for one target port; misses are
// absorbed here and turned into a DECERR burst request.
module axi_ar_route_decoder
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 2,
  parameter int N_REGION    = 2,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arvalid_i,
  input  logic [AXI_ADDR_W-1:0]  araddr_i,
  input  logic [7:0]             arlen_i,
  input  logic [AXI_ID_IN-1:0]   arid_i,
  input  logic [AXI_USER_W-1:0]  aruser_i,
  output logic                   arready_o,
  output logic [N_INIT_PORT-1:0] arvalid_o,
  input  logic [N_INIT_PORT-1:0] arready_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][AXI_ADDR_W-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][AXI_ADDR_W-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0] enable_region_i,
  input  logic [N_INIT_PORT-1:0] connectivity_map_i,
  output logic                   incr_req_o,
  input  logic                   full_counter_i,
  output logic                   error_req_o,
  input  logic                   error_gnt_i,
  output logic [7:0]             error_len_o,
  output logic [AXI_ID_IN-1:0]   error_id_o,
  output logic [AXI_USER_W-1:0]  error_user_o,
  output logic                   sample_ardata_info_o
);

  logic [N_INIT_PORT-1:0] hit;
  logic [N_INIT_PORT-1:0] sel;
  logic                   miss;
  logic                   take_miss;

  ar_dec_state_e state;
  ar_dec_state_e state_nxt;

  logic [7:0]            err_len;
  logic [AXI_ID_IN-1:0]  err_id;
  logic [AXI_USER_W-1:0] err_user;

  axi_region_match #(
    .N_INIT_PORT (N_INIT_PORT),
    .N_REGION    (N_REGION),
    .AXI_ADDR_W  (AXI_ADDR_W)
  ) u_match (
    .addr       (araddr_i),
    .start_addr (START_ADDR_i),
    .end_addr   (END_ADDR_i),
    .enable     (enable_region_i),
    .conn       (connectivity_map_i),
    .hit        (hit),
    .sel        (sel),
    .miss       (miss)
  );

  assign take_miss = (state == AR_OPERATIVE) & arvalid_i &
                     ~full_counter_i & miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AR_OPERATIVE;
      err_len  <= '0;
      err_id   <= '0;
      err_user <= '0;
    end else begin
      state <= state_nxt;
      if (take_miss) begin
        err_len  <= arlen_i;
        err_id   <= arid_i;
        err_user <= aruser_i;
      end
    end
  end

  always_comb begin
    state_nxt            = state;
    arvalid_o            = '0;
    arready_o            = 1'b0;
    incr_req_o           = 1'b0;
    sample_ardata_info_o = 1'b0;
    error_req_o          = 1'b0;
    unique case (state)
      AR_OPERATIVE: begin
        if (arvalid_i && !full_counter_i) begin
          if (miss) begin
            arready_o            = 1'b1;
            sample_ardata_info_o = 1'b1;
            state_nxt            = AR_ERROR;
          end else begin
            arvalid_o  = sel;
            arready_o  = |(arready_i & sel);
            incr_req_o = arready_o;
          end
        end
      end
      AR_ERROR: begin
        error_req_o = 1'b1;
        if (error_gnt_i) state_nxt = AR_OPERATIVE;
      end
      default: ;
    endcase
    // Handshake/request outputs are quiet while reset is held
    if (rst) begin
      arvalid_o            = '0;
      arready_o            = 1'b0;
      incr_req_o           = 1'b0;
      sample_ardata_info_o = 1'b0;
      error_req_o          = 1'b0;
    end
  end

  // Live AR fields while operative so the acceptance-cycle sample is current
  assign error_len_o  = (state == AR_ERROR) ? err_len  : arlen_i;
  assign error_id_o   = (state == AR_ERROR) ? err_id   : arid_i;
  assign error_user_o = (state == AR_ERROR) ? err_user : aruser_i;

endmodule

// File: tb/tb_axi_ar_route_decoder.sv
// Bench for axi_ar_route_decoder: directed scenarios then random
// traffic, all checked against a region-table reference model.
module tb_axi_ar_route_decoder;
  import axi_node_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         arvalid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [15:0]  arid;
  logic [5:0]   aruser;
  logic         arready_o;
  logic [1:0]   arvalid_o;
  logic [1:0]   ardy_dn;
  region_addr_t sa;
  region_addr_t ea;
  region_en_t   en;
  logic [1:0]   conn;
  logic         incr_o;
  logic         full;
  logic         ereq_o;
  logic         gnt;
  logic [7:0]   elen_o;
  logic [15:0]  eid_o;
  logic [5:0]   euser_o;
  logic         smp_o;

  int vectors = 0;
  int miscompares = 0;

  bit          m_err;
  logic [7:0]  m_len;
  logic [15:0] m_id;
  logic [5:0]  m_user;

  always #5 clk = ~clk;

  axi_ar_route_decoder dut (
    .clk                  (clk),
    .rst                  (rst),
    .arvalid_i            (arvalid),
    .araddr_i             (araddr),
    .arlen_i              (arlen),
    .arid_i               (arid),
    .aruser_i             (aruser),
    .arready_o            (arready_o),
    .arvalid_o            (arvalid_o),
    .arready_i            (ardy_dn),
    .START_ADDR_i         (sa),
    .END_ADDR_i           (ea),
    .enable_region_i      (en),
    .connectivity_map_i   (conn),
    .incr_req_o           (incr_o),
    .full_counter_i       (full),
    .error_req_o          (ereq_o),
    .error_gnt_i          (gnt),
    .error_len_o          (elen_o),
    .error_id_o           (eid_o),
    .error_user_o         (euser_o),
    .sample_ardata_info_o (smp_o)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Index of the initiator the address routes to, or -1 on a miss
  function automatic int target(logic [31:0] a);
    for (int j = 0; j < 2; j++)
      if (conn[j])
        for (int r = 0; r < 2; r++)
          if (en[r][j] && a >= sa[r][j] && a <= ea[r][j]) return j;
    return -1;
  endfunction

  task automatic ar(logic v, logic [31:0] a, logic [7:0] l,
                    logic [15:0] i, logic [5:0] u, logic [1:0] rdy);
    arvalid = v; araddr = a; arlen = l;
    arid = i; aruser = u; ardy_dn = rdy;
  endtask

  // Inputs are set just after a rising edge; check mid-cycle, then
  // advance the model across the next rising edge.
  task automatic cycle();
    int t;
    logic [1:0] e_v;
    logic e_rdy, e_inc, e_smp, e_req;
    #4;
    t = target(araddr);
    e_v = '0; e_rdy = 0; e_inc = 0; e_smp = 0; e_req = 0;
    if (!rst) begin
      if (m_err) e_req = 1'b1;
      else if (arvalid && !full) begin
        if (t < 0) begin
          e_rdy = 1'b1;
          e_smp = 1'b1;
        end else begin
          e_v[t] = 1'b1;
          e_rdy  = ardy_dn[t];
          e_inc  = ardy_dn[t];
        end
      end
    end
    check("arvalid_o", 32'(arvalid_o), 32'(e_v));
    check("arready_o", 32'(arready_o), 32'(e_rdy));
    check("incr_req", 32'(incr_o), 32'(e_inc));
    check("sample", 32'(smp_o), 32'(e_smp));
    check("error_req", 32'(ereq_o), 32'(e_req));
    check("error_len", 32'(elen_o), 32'(m_err ? m_len : arlen));
    check("error_id", 32'(eid_o), 32'(m_err ? m_id : arid));
    check("error_user", 32'(euser_o), 32'(m_err ? m_user : aruser));
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_len = '0; m_id = '0; m_user = '0;
    end else if (m_err) begin
      if (gnt) m_err = 0;
    end else if (arvalid && !full && t < 0) begin
      m_err = 1; m_len = arlen; m_id = arid; m_user = aruser;
    end
    #1;
  endtask

  initial begin
    sa = '0; ea = '0; en = '0;
    sa[0][0] = 32'h1000_0000; ea[0][0] = 32'h1FFF_FFFF;
    sa[0][1] = 32'h2000_0000; ea[0][1] = 32'h2FFF_FFFF;
    en[0] = 2'b11;
    conn = 2'b11;
    full = 0; gnt = 0; rst = 1;
    m_err = 0; m_len = '0; m_id = '0; m_user = '0;
    ar(0, 32'h0, 8'h0, 16'h0, 6'h0, 2'b00);
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 0;

    // Routed hit
    ar(1, 32'h1000_0004, 8'h1, 16'h7, 6'h1, 2'b01);
    cycle();
    // Miss, then hold ERROR with changed inputs, then grant
    ar(1, 32'h3000_0000, 8'd3, 16'd5, 6'd2, 2'b11);
    cycle();
    ar(1, 32'h3000_0000, 8'd0, 16'd9, 6'd0, 2'b11);
    cycle();
    cycle();
    gnt = 1;
    cycle();
    gnt = 0;
    ar(1, 32'h1000_0100, 8'd2, 16'd1, 6'd3, 2'b01);
    cycle();
    // Saturated counter blocks a hit
    full = 1;
    ar(1, 32'h2000_0000, 8'd0, 16'd2, 6'd0, 2'b10);
    repeat (5) cycle();
    full = 0;
    cycle();
    // Priority and connectivity
    sa[1][0] = 32'h2000_0000; ea[1][0] = 32'h2000_FFFF;
    en[1][0] = 1'b1;
    ar(1, 32'h2000_0010, 8'd0, 16'd3, 6'd0, 2'b11);
    cycle();
    conn = 2'b10;
    cycle();
    conn = 2'b00;
    cycle();
    gnt = 1;
    cycle();
    gnt = 0;
    conn = 2'b11;
    en[1][0] = 1'b0;
    // Boundaries
    ar(1, 32'h1FFF_FFFF, 8'd0, 16'd4, 6'd0, 2'b11);
    cycle();
    ar(1, 32'h2000_0000, 8'd0, 16'd4, 6'd0, 2'b10);
    cycle();
    en[0][1] = 1'b0;
    cycle();
    en[0][1] = 1'b1;
    // Reset while in ERROR
    ar(1, 32'h0000_0040, 8'd7, 16'd8, 6'd9, 2'b00);
    cycle();
    arvalid = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    ar(1, 32'h2000_0040, 8'd1, 16'd6, 6'd4, 2'b10);
    cycle();

    // Random traffic
    sa[1][0] = 32'h2000_0000; ea[1][0] = 32'h2000_FFFF;
    en = 4'b0111;
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 60) == 0);
      arvalid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: araddr = $urandom;
        1: araddr = 32'h1000_0000 + 32'($urandom_range(0, 255));
        2: araddr = 32'h2000_0000 - 32'($urandom_range(0, 2));
        3: araddr = 32'h2000_FFFF + 32'($urandom_range(0, 2));
        default: araddr = 32'h2FFF_FFFF + 32'($urandom_range(0, 2));
      endcase
      arlen   = 8'($urandom);
      arid    = 16'($urandom);
      aruser  = 6'($urandom);
      ardy_dn = 2'($urandom_range(0, 3));
      full    = ($urandom_range(0, 7) == 0);
      gnt     = ($urandom_range(0, 2) == 0);
      if (!arvalid && $urandom_range(0, 7) == 0) begin
        conn = 2'($urandom_range(0, 3));
        en   = 4'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
